// File: rtl/dequant_reconstruct_uv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dequant_reconstruct_uv_pkg
// Brief   : Shared constants, state encoding and slice mapping helpers for
//           chroma dequantisation and reconstruction.
// Revision: 1.0
// ============================================================================
package dequant_reconstruct_uv_pkg;

    localparam int LEV_W  = 2048;
    localparam int PRED_W = 1024;
    localparam int Q_W    = 256;
    localparam int NZ_W   = 32;

    localparam int K1 = 20091;
    localparam int K2 = 35468;

    localparam logic signed [32:0] SAT_MAX = 33'sd32767;
    localparam logic signed [32:0] SAT_MIN = -33'sd32768;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DEQ  = 3'd1;
    localparam logic [2:0] ST_VERT = 3'd2;
    localparam logic [2:0] ST_HORZ = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    function automatic logic [2:0] slice_row_base(input logic [2:0] k);
        return {k[2], 2'b00};
    endfunction

    function automatic logic [3:0] slice_col_base(input logic [2:0] k);
        return {k[1], k[0], 2'b00};
    endfunction

    // Offset of the slice's flag above bit 16 of the nz word
    function automatic logic [2:0] slice_nz_idx(input logic [2:0] k);
        return {k[1], k[2], k[0]};
    endfunction

    function automatic logic [9:0] pix_bit_base(input logic [2:0] k,
                                                input logic [1:0] r,
                                                input logic [1:0] x);
        logic [2:0] row;
        logic [3:0] col;
        row = slice_row_base(k) | {1'b0, r};
        col = slice_col_base(k) | {2'b00, x};
        return {row, col, 3'b000};
    endfunction

    function automatic logic signed [15:0] sat_mul(input logic signed [15:0] lev,
                                                   input logic [15:0]        qf);
        logic signed [32:0] p;
        p = 33'(lev) * $signed({17'b0, qf});
        if (p > SAT_MAX) return 16'sh7fff;
        if (p < SAT_MIN) return -16'sh8000;
        return p[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dequant_reconstruct_uv_if.sv
`default_nettype none
// ============================================================================
// Module  : dequant_reconstruct_uv_if
// Brief   : Request/result bundle between a macroblock source and the chroma
//           reconstruction block.
// Revision: 1.0
// ============================================================================
interface dequant_reconstruct_uv_if;
    import dequant_reconstruct_uv_pkg::*;

    logic              start;
    logic [LEV_W-1:0]  UVlevels;
    logic [PRED_W-1:0] UVPred;
    logic [Q_W-1:0]    q;
    logic [NZ_W-1:0]   nz;
    logic [PRED_W-1:0] UVout;
    logic              busy;
    logic              done;

    modport master (output start, UVlevels, UVPred, q, nz,
                    input  UVout, busy, done);
    modport slave  (input  start, UVlevels, UVPred, q, nz,
                    output UVout, busy, done);
endinterface
`default_nettype wire

// File: rtl/dequant_reconstruct_uv_idct4x4_pass.sv
`default_nettype none
// ============================================================================
// Module  : dequant_reconstruct_uv_idct4x4_pass
// Brief   : Combinational 4-point inverse butterfly; ROUND adds the +4 bias
//           and the final >>>3 used by the second (row) pass.
// Revision: 1.0
// ============================================================================
module dequant_reconstruct_uv_idct4x4_pass
    import dequant_reconstruct_uv_pkg::*;
#(
    parameter int CW    = 24,
    parameter bit ROUND = 1'b0
)(
    input  logic signed [CW-1:0] i_x0,
    input  logic signed [CW-1:0] i_x1,
    input  logic signed [CW-1:0] i_x2,
    input  logic signed [CW-1:0] i_x3,
    output logic signed [CW-1:0] o_y0,
    output logic signed [CW-1:0] o_y1,
    output logic signed [CW-1:0] o_y2,
    output logic signed [CW-1:0] o_y3
);

    localparam int c_PW = CW + 17;
    localparam int c_SH = ROUND ? 3 : 0;
    localparam logic signed [CW-1:0] c_RND = ROUND ? CW'(4) : CW'(0);

    // Products are formed wide so the >>>16 never loses sign or magnitude
    function automatic logic signed [CW-1:0] mul1(input logic signed [CW-1:0] x);
        return x + CW'((c_PW'(x) * c_PW'(K1)) >>> 16);
    endfunction

    function automatic logic signed [CW-1:0] mul2(input logic signed [CW-1:0] x);
        return CW'((c_PW'(x) * c_PW'(K2)) >>> 16);
    endfunction

    logic signed [CW-1:0] w_dc;
    logic signed [CW-1:0] w_a;
    logic signed [CW-1:0] w_b;
    logic signed [CW-1:0] w_c;
    logic signed [CW-1:0] w_d;

    assign w_dc = i_x0 + c_RND;
    assign w_a  = w_dc + i_x2;
    assign w_b  = w_dc - i_x2;
    assign w_c  = mul2(i_x1) - mul1(i_x3);
    assign w_d  = mul1(i_x1) + mul2(i_x3);

    assign o_y0 = (w_a + w_d) >>> c_SH;
    assign o_y1 = (w_b + w_c) >>> c_SH;
    assign o_y2 = (w_b - w_c) >>> c_SH;
    assign o_y3 = (w_a - w_d) >>> c_SH;

endmodule
`default_nettype wire

// File: rtl/dequant_reconstruct_uv.sv
`default_nettype none
// ============================================================================
// Module  : dequant_reconstruct_uv
// Brief   : Sequential per-block chroma dequant, 4x4 inverse transform,
//           prediction add and clip for one macroblock (4 U + 4 V blocks).
// Revision: 1.0
// ============================================================================
module dequant_reconstruct_uv
    import dequant_reconstruct_uv_pkg::*;
#(
    parameter int BLOCK_SIZE = 8,
    parameter int CW         = 24
)(
    input  logic                     clk,
    input  logic                     rst_n,
    dequant_reconstruct_uv_if.slave  bus
);

    logic [2:0]           r_state;
    logic [2:0]           r_k;
    logic [LEV_W-1:0]     r_levels;
    logic [PRED_W-1:0]    r_pred;
    logic [Q_W-1:0]       r_q;
    logic [7:0]           r_nzk;
    logic signed [CW-1:0] r_coef [16];
    logic signed [CW-1:0] r_vt   [16];
    logic [7:0]           r_pix  [16];
    logic [PRED_W-1:0]    r_uvout;

    logic [7:0]           w_nz_in;
    logic signed [CW-1:0] w_coef    [16];
    logic signed [CW-1:0] w_vt      [16];
    logic signed [CW-1:0] w_hz      [16];
    logic signed [CW-1:0] w_sum     [16];
    logic [7:0]           w_pred_px [16];
    logic [7:0]           w_pix     [16];
    logic                 w_unused_nz;

    // Only the eight chroma flags are meaningful; the rest is don't-care
    always_comb begin
        w_nz_in = '0;
        for (int k = 0; k < 8; k++) begin
            w_nz_in[k] = bus.nz[{2'b10, slice_nz_idx(3'(k))}];
        end
    end
    assign w_unused_nz = ^{bus.nz[31:24], bus.nz[15:0]};

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_coef[n] = CW'(sat_mul(r_levels[{r_k, 4'(n), 4'b0000} +: 16],
                                    r_q[{4'(n), 4'b0000} +: 16]));
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_col
        dequant_reconstruct_uv_idct4x4_pass #(.CW(CW), .ROUND(1'b0)) u_vert (
            .i_x0 (r_coef[i]),     .i_x1 (r_coef[4+i]),
            .i_x2 (r_coef[8+i]),   .i_x3 (r_coef[12+i]),
            .o_y0 (w_vt[i]),       .o_y1 (w_vt[4+i]),
            .o_y2 (w_vt[8+i]),     .o_y3 (w_vt[12+i])
        );
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        dequant_reconstruct_uv_idct4x4_pass #(.CW(CW), .ROUND(1'b1)) u_horz (
            .i_x0 (r_vt[4*r]),     .i_x1 (r_vt[4*r+1]),
            .i_x2 (r_vt[4*r+2]),   .i_x3 (r_vt[4*r+3]),
            .o_y0 (w_hz[4*r]),     .o_y1 (w_hz[4*r+1]),
            .o_y2 (w_hz[4*r+2]),   .o_y3 (w_hz[4*r+3])
        );
    end

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_pred_px[n] = r_pred[pix_bit_base(r_k, 2'(n / 4), 2'(n % 4)) +: 8];
            w_sum[n]     = w_hz[n] + $signed({{(CW-8){1'b0}}, w_pred_px[n]});
            if (w_sum[n] < 0) begin
                w_pix[n] = 8'd0;
            end else if (w_sum[n] > CW'(255)) begin
                w_pix[n] = 8'hff;
            end else begin
                w_pix[n] = w_sum[n][7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.start) begin
            r_levels <= bus.UVlevels;
            r_pred   <= bus.UVPred;
            r_q      <= bus.q;
            r_nzk    <= w_nz_in;
        end
        if (r_state == ST_DEQ)  r_coef <= w_coef;
        if (r_state == ST_VERT) r_vt   <= w_vt;
        if (r_state == ST_HORZ) r_pix  <= w_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_uvout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_k     <= '0;
                        r_state <= w_nz_in[0] ? ST_DEQ : ST_WB;
                    end
                end
                ST_DEQ:  r_state <= ST_VERT;
                ST_VERT: r_state <= ST_HORZ;
                ST_HORZ: r_state <= ST_WB;
                ST_WB: begin
                    // A clear flag forces a pure prediction copy
                    for (int n = 0; n < 16; n++) begin
                        r_uvout[pix_bit_base(r_k, 2'(n / 4), 2'(n % 4)) +: 8] <=
                            r_nzk[r_k] ? r_pix[n] : w_pred_px[n];
                    end
                    if (r_k == 3'(BLOCK_SIZE - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= r_nzk[r_k + 3'd1] ? ST_DEQ : ST_WB;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.UVout = r_uvout;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dequant_reconstruct_uv.sv
`default_nettype none
// ============================================================================
// Module  : tb_dequant_reconstruct_uv
// Brief   : Directed scoreboard bench for chroma dequant/reconstruction.
// Revision: 1.0
// ============================================================================
module tb_dequant_reconstruct_uv;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    typedef struct {
        logic [1023:0] uv;
        int            lat;
    } exp_t;

    exp_t sb[$];

    dequant_reconstruct_uv_if bus();

    dequant_reconstruct_uv #(.BLOCK_SIZE(8), .CW(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint m1(input longint x);
        return x + ((x * 20091) >>> 16);
    endfunction

    function automatic longint m2(input longint x);
        return (x * 35468) >>> 16;
    endfunction

    function automatic int nz_bit(input int k);
        return 16 + ((k >> 1) & 1) * 4 + ((k >> 2) & 1) * 2 + (k & 1);
    endfunction

    function automatic logic [1023:0] model(input logic [2047:0] lev,
                                            input logic [1023:0] pred,
                                            input logic [255:0]  qq,
                                            input logic [31:0]   nzv);
        logic [1023:0] res;
        longint c [16];
        longint t [16];
        longint o [4];
        longint a, b, cc, d, dc, p, v;
        int rb, cb;
        res = pred;
        for (int k = 0; k < 8; k++) begin
            rb = ((k >> 2) & 1) * 4;
            cb = ((k >> 1) & 1) * 8 + (k & 1) * 4;
            if (nzv[nz_bit(k)]) begin
                for (int n = 0; n < 16; n++) begin
                    p = longint'($signed(lev[256*k + 16*n +: 16])) * longint'(qq[16*n +: 16]);
                    c[n] = (p > 32767) ? 32767 : ((p < -32768) ? -32768 : p);
                end
                for (int i = 0; i < 4; i++) begin
                    a  = c[i] + c[8+i];
                    b  = c[i] - c[8+i];
                    cc = m2(c[4+i]) - m1(c[12+i]);
                    d  = m1(c[4+i]) + m2(c[12+i]);
                    t[i] = a + d;  t[4+i] = b + cc;  t[8+i] = b - cc;  t[12+i] = a - d;
                end
                for (int r = 0; r < 4; r++) begin
                    dc = t[4*r] + 4;
                    a  = dc + t[4*r+2];
                    b  = dc - t[4*r+2];
                    cc = m2(t[4*r+1]) - m1(t[4*r+3]);
                    d  = m1(t[4*r+1]) + m2(t[4*r+3]);
                    o[0] = (a + d) >>> 3;  o[1] = (b + cc) >>> 3;
                    o[2] = (b - cc) >>> 3; o[3] = (a - d) >>> 3;
                    for (int x = 0; x < 4; x++) begin
                        v = o[x] + longint'(pred[128*(rb+r) + 8*(cb+x) +: 8]);
                        if (v < 0) v = 0;
                        if (v > 255) v = 255;
                        res[128*(rb+r) + 8*(cb+x) +: 8] = v[7:0];
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] px(input logic [1023:0] uv, input int row, input int col);
        return uv[128*row + 8*col +: 8];
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_mb(input string tag, input logic [2047:0] lev, input logic [1023:0] pred,
                          input logic [255:0] qq, input logic [31:0] nzv, input int dup_at);
        exp_t e;
        int   lat;
        int   nnz;
        int   extra;
        nnz = 0;
        for (int k = 0; k < 8; k++) if (nzv[nz_bit(k)]) nnz++;
        e.uv  = model(lev, pred, qq, nzv);
        e.lat = 1 + 4 * nnz + (8 - nnz);
        sb.push_back(e);

        @(negedge clk);
        bus.UVlevels = lev;  bus.UVPred = pred;  bus.q = qq;  bus.nz = nzv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        chk({tag, " busy_after_start"}, 1024'(bus.busy), 1024'(1));
        while (bus.done !== 1'b1 && lat < 80) begin
            if (lat == dup_at) begin
                bus.start  = 1'b1;
                bus.UVPred = ~pred;
                bus.nz     = ~nzv;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, " done_seen"}, 1024'(bus.done), 1024'(1));
        chk({tag, " latency"}, 1024'(lat), 1024'(e.lat));
        chk({tag, " uvout"}, bus.UVout, e.uv);
        chk({tag, " busy_in_done"}, 1024'(bus.busy), 1024'(1));
        @(posedge clk); #1;
        chk({tag, " idle_after"}, 1024'({bus.busy, bus.done}), 1024'(0));
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        chk({tag, " no_extra_done"}, 1024'(extra), 1024'(0));
        chk({tag, " uvout_hold"}, bus.UVout, e.uv);
    endtask

    logic [2047:0] lev;
    logic [1023:0] pred;
    logic [255:0]  qv;
    logic [31:0]   nzv;

    task automatic rand_small;
        for (int n = 0; n < 128; n++) lev[16*n +: 16] = 16'($urandom_range(0, 200) - 100);
        for (int n = 0; n < 16; n++)  qv[16*n +: 16]  = 16'($urandom_range(1, 64));
        for (int n = 0; n < 128; n++) pred[8*n +: 8]  = 8'($urandom);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0;  bus.UVlevels = '0;  bus.UVPred = '0;  bus.q = '0;  bus.nz = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset uvout", bus.UVout, '0);
        chk("reset busy", 1024'(bus.busy), 1024'(0));
        chk("reset done", 1024'(bus.done), 1024'(0));
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_in_reset ignored", 1024'(bus.busy), 1024'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // All blocks bypassed: output is the prediction ramp
        lev = '0;  qv = {16{16'd8}};  nzv = '0;
        for (int n = 0; n < 128; n++) pred[8*n +: 8] = 8'(n);
        run_mb("t1_bypass", lev, pred, qv, nzv, -1);
        chk("t1 equals pred", bus.UVout, pred);

        lev = '0;  lev[15:0] = 16'd1;  qv = '0;  qv[15:0] = 16'd8;
        nzv = 32'h0001_0000;  pred = {128{8'd100}};
        run_mb("t2_dc", lev, pred, qv, nzv, -1);
        chk("t2 px(0,0)", 1024'(px(bus.UVout, 0, 0)), 1024'(101));
        chk("t2 px(3,3)", 1024'(px(bus.UVout, 3, 3)), 1024'(101));
        chk("t2 px(0,4)", 1024'(px(bus.UVout, 0, 4)), 1024'(100));
        chk("t2 px(4,0)", 1024'(px(bus.UVout, 4, 0)), 1024'(100));

        lev = '0;  lev[15:0] = 16'h7fff;  qv = '0;  qv[15:0] = 16'd127;  pred = {128{8'd255}};
        run_mb("t3_satpos", lev, pred, qv, nzv, -1);
        chk("t3 px(2,1) clip hi", 1024'(px(bus.UVout, 2, 1)), 1024'(255));
        lev[15:0] = 16'h8000;
        run_mb("t3_satneg", lev, pred, qv, nzv, -1);
        chk("t3 px(1,2) clip lo", 1024'(px(bus.UVout, 1, 2)), 1024'(0));
        chk("t3 px(0,5) pred", 1024'(px(bus.UVout, 0, 5)), 1024'(255));

        // Slice 5 carries levels but its flag is clear; junk in ignored nz bits
        rand_small();
        nzv = 32'hA5F7_3C5A;
        run_mb("t4_nzauth", lev, pred, qv, nzv, -1);
        for (int r = 4; r < 8; r++) begin
            chk("t4 slice5 row", 1024'(bus.UVout[128*r + 32 +: 32]), 1024'(pred[128*r + 32 +: 32]));
        end

        lev = '0;  lev[512 +: 16] = 16'd1;  qv = '0;  qv[15:0] = 16'd8;
        nzv = 32'h0010_0000;  pred = {128{8'd50}};
        run_mb("t5_slice2", lev, pred, qv, nzv, -1);
        chk("t5 px(0,8)", 1024'(px(bus.UVout, 0, 8)), 1024'(51));
        chk("t5 px(3,11)", 1024'(px(bus.UVout, 3, 11)), 1024'(51));
        chk("t5 px(0,7)", 1024'(px(bus.UVout, 0, 7)), 1024'(50));
        chk("t5 px(0,12)", 1024'(px(bus.UVout, 0, 12)), 1024'(50));
        chk("t5 px(4,8)", 1024'(px(bus.UVout, 4, 8)), 1024'(50));

        rand_small();
        nzv = 32'h00C3_0000;
        run_mb("t6_dupstart", lev, pred, qv, nzv, 3);

        // Abort mid-run with asynchronous reset
        rand_small();
        @(negedge clk);
        bus.UVlevels = lev;  bus.UVPred = pred;  bus.q = qv;  bus.nz = 32'h00FF_0000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort uvout", bus.UVout, '0);
        chk("abort busy", 1024'(bus.busy), 1024'(0));
        chk("abort done", 1024'(bus.done), 1024'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 64; n++) lev[32*n +: 32] = $urandom;
        for (int n = 0; n < 8; n++)  qv[32*n +: 32]  = $urandom;
        for (int n = 0; n < 32; n++) pred[32*n +: 32] = $urandom;
        nzv = $urandom;
        run_mb("t7_fresh", lev, pred, qv, nzv, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dequant_reconstruct_uv.md
Name: dequant_reconstruct_uv

Overview:
Decoder-side chroma reconstruction for one macroblock, the inverse of the encoder's UV forward path. It takes the quantized UV levels (8 blocks of 4x4) and the UV prediction, and dequantizes each block with q. It then applies the 4x4 inverse transform, adds the prediction and clips to 8 bits, producing reconstructed U/V pixels. Blocks are processed sequentially through one shared datapath; blocks whose nz flag is clear are bypassed.

Parameters:
BLOCK_SIZE, 8, number of 4x4 chroma blocks per macroblock (fixed; 4 U + 4 V).
CW, 24, signed width of internal transform intermediates.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
UVlevels  in  2048  8 slices of 256 bits, 16 signed 16-bit coeffs each in raster zigzag-free order. Slice k maps to: row band k[2], plane k[1] (0=U, 1=V), column half k[0].
UVPred  in  1024  8 rows x 16 bytes; row r = bits [128r+127:128r]; bytes 0-7 U, 8-15 V.
q  in  256  16-bit dequant factor per coefficient position n at [16n+15:16n]; n=0 is DC.
nz  in  32  nonzero flags; slice k uses bit 16+{k[1],k[2],k[0]}; other bits ignored.
UVout  out  1024  reconstructed pixels, same layout as UVPred.
busy  out  1  block is processing.
done  out  1  one-cycle pulse; UVout valid.

Behaviour:
- Reset (async): state=IDLE, k=0; UVout=0, busy=0, done=0. Reset mid-operation aborts immediately with the same values.
- IDLE: on start=1, latch UVlevels, UVPred, q and nz into internal registers, set k=0 and go to DEQ (or WB if nz bit for slice 0 is clear). Inputs may change after the start cycle.
- DEQ (1 cycle):
  - Compute c[n] = level[n]*q[n] as a 32-bit signed product.
  - Saturate to signed 16 bits ([-32768, 32767]).
- VERT (1 cycle): column pass per column i.
  - a=c0+c8, b=c0-c8, c=M2(c4)-M1(c12), d=M1(c4)+M2(c12).
  - t = {a+d, b+c, b-c, a-d}.
  - M1(x) = x + ((x*20091)>>>16); M2(x) = (x*35468)>>>16. Arithmetic shifts, CW-bit intermediates, no intermediate clipping.
- HORZ (1 cycle): row pass.
  - dc = t0+4; a=dc+t8, b=dc-t8, c=M2(t4)-M1(t12), d=M1(t4)+M2(t12).
  - Outputs (a+d, b+c, b-c, a-d)>>>3.
  - Add the corresponding pred byte (unsigned) and clip to [0,255].
- WB (1 cycle):
  - Write the 4x4 result into the UVout region of slice k.
  - For a bypassed slice (nz bit clear), copy the pred bytes unchanged, even if the levels are nonzero. The nz flag is authoritative.
  - Then k+1; go to DEQ or WB per the next nz bit; after k=7 go to DONE.
- DONE (1 cycle): done=1, busy=1; next cycle return to IDLE with busy=0.
- busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
- Latency: done is asserted N cycles after the start cycle, with N = 1 + 4*(nonzero slices) + 1*(bypassed slices). Range 9..33.
- UVout holds its value from DONE until the next WB write. Regions not yet rewritten keep the previous macroblock's value.
- start while busy: ignored, no queuing. start coincident with rst_n low: ignored.

Decomposition:
- Shared package contents:
  - Transform constants K1=20091 and K2=35468.
  - Saturation bounds.
  - State encoding IDLE/DEQ/VERT/HORZ/WB/DONE.
  - Slice-to-region and slice-to-nz-bit mapping functions.
- One natural sub-module, idct4x4_pass: a combinational 1-D 4-point inverse butterfly with M1/M2. It is instantiated twice, once for the vertical and once for the horizontal pass with rounding/shift enabled. The FSM, registers and pred-add/clip stay in the top module.

Test Plan:
1. Ramp pred (byte = index mod 256), all levels 0, nz=0, start -> done exactly 9 cycles after start; UVout == UVPred.
2. Slice 0 level[0]=1, q[15:0]=8, nz[16]=1, pred all 100 -> rows 0-3, bytes 0-3 = 101, every other byte 100; done at cycle 12.
3. Slice 0 level[0]=32767, q=127, pred 255 -> dequant saturates to 32767 and the slice clips to 255. Repeat with level -32768 -> slice clips to 0.
4. Slice 5 has nonzero levels but nz[19]=0 -> slice 5 region (rows 4-7, U bytes 4-7) equals pred; latency counts it as 1 cycle.
5. Slice 2 level[0]=1, q=8, nz[20]=1, pred 50 -> only rows 0-3, bytes 8-11 (V top-left) become 51.
6. start pulsed while busy -> ignored, single done. rst_n low at cycle 5 of a run -> UVout=0, busy=0, done=0 immediately; a fresh start then completes normally.
